// File: rtl/layered_pixel_generator.sv
// Instruction-programmed pixel source: background plus NUM_RECTS filled rectangles,
// double-buffered (staging -> active on frame start after COMMIT), 2-cycle pixel latency.
module layered_pixel_generator #(
   parameter int unsigned        COORD_W   = 10,
   parameter int unsigned        COLOR_W   = 12,
   parameter int unsigned        NUM_RECTS = 4,
   parameter logic [COLOR_W-1:0] RESET_BG  = 12'hf00
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [COORD_W-1:0] i_pixel_x,
   input  logic [COORD_W-1:0] i_pixel_y,
   input  logic               i_frame_start,
   input  logic [31:0]        i_instruction,
   input  logic               i_instruction_ready,
   output logic [COLOR_W-1:0] o_color,
   output logic               o_commit_pending,
   output logic               o_error
);

   localparam int unsigned SEL_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;

   localparam logic [7:0] OpSetBg    = 8'h01;
   localparam logic [7:0] OpSelect   = 8'h02;
   localparam logic [7:0] OpSetX     = 8'h03;
   localparam logic [7:0] OpSetY     = 8'h04;
   localparam logic [7:0] OpSetColor = 8'h05;
   localparam logic [7:0] OpClear    = 8'h06;
   localparam logic [7:0] OpCommit   = 8'h07;
   localparam logic [7:0] OpClrErr   = 8'h08;

   typedef struct packed {
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] y1;
      logic [COLOR_W-1:0] color;
      logic               en;
   } rect_t;

   rect_t [NUM_RECTS-1:0] stg_q, stg_d, act_q, act_d;
   logic  [COLOR_W-1:0]   stg_bg_q, stg_bg_d, act_bg_q, act_bg_d;
   logic  [SEL_W-1:0]     sel_q, sel_d;
   logic                  err_q, err_d;
   logic                  pend_q, pend_d;

   logic [NUM_RECTS-1:0]                hit_q, hit_d;
   logic [NUM_RECTS-1:0][COLOR_W-1:0]   s1_col_q, s1_col_d;
   logic [COLOR_W-1:0]                  s1_bg_q, s1_bg_d;
   logic [COLOR_W-1:0]                  color_q, color_d;

   logic [7:0]  opcode;
   logic [23:0] args;
   logic        commit_now;
   logic        do_copy;

   assign opcode = i_instruction[7:0];
   assign args   = i_instruction[31:8];

   // Instruction decode and frame-boundary copy
   always_comb begin
      stg_d      = stg_q;
      stg_bg_d   = stg_bg_q;
      act_d      = act_q;
      act_bg_d   = act_bg_q;
      sel_d      = sel_q;
      err_d      = err_q;
      pend_d     = pend_q;
      commit_now = 1'b0;
      if (i_instruction_ready) begin
         case (opcode)
            OpSetBg: stg_bg_d = args[COLOR_W-1:0];
            OpSelect: begin
               if (32'(args[7:0]) >= NUM_RECTS) err_d = 1'b1;
               else                             sel_d = args[SEL_W-1:0];
            end
            OpSetX: begin
               stg_d[sel_q].x0 = args[COORD_W-1:0];
               stg_d[sel_q].x1 = args[COORD_W+11:12];
            end
            OpSetY: begin
               stg_d[sel_q].y0 = args[COORD_W-1:0];
               stg_d[sel_q].y1 = args[COORD_W+11:12];
            end
            OpSetColor: begin
               stg_d[sel_q].color = args[COLOR_W-1:0];
               stg_d[sel_q].en    = args[16];
            end
            OpClear: begin
               for (int k = 0; k < int'(NUM_RECTS); k++) stg_d[k].en = 1'b0;
            end
            OpCommit: commit_now = 1'b1;
            OpClrErr: err_d = 1'b0;
            default:  err_d = 1'b1;
         endcase
      end
      // Copy takes the pre-write staging values so a same-cycle write lands next frame
      do_copy = i_frame_start && (pend_q || commit_now);
      if (do_copy) begin
         act_d    = stg_q;
         act_bg_d = stg_bg_q;
         pend_d   = 1'b0;
      end else if (commit_now) begin
         pend_d = 1'b1;
      end
   end

   // Stage 1 hit vector and stage 2 lowest-index priority select
   always_comb begin
      hit_d    = '0;
      s1_col_d = '0;
      s1_bg_d  = act_bg_q;
      for (int k = 0; k < int'(NUM_RECTS); k++) begin
         hit_d[k] = act_q[k].en &&
                    (i_pixel_x >= act_q[k].x0) && (i_pixel_x <= act_q[k].x1) &&
                    (i_pixel_y >= act_q[k].y0) && (i_pixel_y <= act_q[k].y1);
         s1_col_d[k] = act_q[k].color;
      end
      color_d = s1_bg_q;
      for (int k = int'(NUM_RECTS) - 1; k >= 0; k--) begin
         if (hit_q[k]) color_d = s1_col_q[k];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         stg_q    <= '0;
         act_q    <= '0;
         stg_bg_q <= RESET_BG;
         act_bg_q <= RESET_BG;
         sel_q    <= '0;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
         hit_q    <= '0;
         s1_col_q <= '0;
         s1_bg_q  <= '0;
         color_q  <= '0;
      end else begin
         stg_q    <= stg_d;
         act_q    <= act_d;
         stg_bg_q <= stg_bg_d;
         act_bg_q <= act_bg_d;
         sel_q    <= sel_d;
         err_q    <= err_d;
         pend_q   <= pend_d;
         hit_q    <= hit_d;
         s1_col_q <= s1_col_d;
         s1_bg_q  <= s1_bg_d;
         color_q  <= color_d;
      end
   end

   assign o_color          = color_q;
   assign o_commit_pending = pend_q;
   assign o_error          = err_q;

endmodule

// File: tb/tb_layered_pixel_generator.sv
// Bench for layered_pixel_generator: directed scenarios then random instructions, all
// checked each cycle against a behavioural model of staging/active sets and pixel latency.
module tb_layered_pixel_generator;

   logic        clk;
   logic        rst;
   logic [9:0]  x, y;
   logic        fs;
   logic [31:0] instr;
   logic        rdy;
   logic [11:0] o_color;
   logic        o_pend, o_err;

   layered_pixel_generator #(
      .COORD_W(10), .COLOR_W(12), .NUM_RECTS(4), .RESET_BG(12'hf00)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_pixel_x(x), .i_pixel_y(y),
      .i_frame_start(fs), .i_instruction(instr), .i_instruction_ready(rdy),
      .o_color(o_color), .o_commit_pending(o_pend), .o_error(o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x0, x1, y0, y1, color;
      bit en;
   } rect_t;

   rect_t m_stg[4], m_act[4];
   int    m_stg_bg, m_act_bg, m_sel;
   bit    m_pend, m_err;
   int    pipe1, exp_color;
   int    errors = 0;
   int    checks = 0;

   function automatic int ref_color(input int px, input int py);
      for (int k = 0; k < 4; k++)
         if (m_act[k].en && px >= m_act[k].x0 && px <= m_act[k].x1 &&
             py >= m_act[k].y0 && py <= m_act[k].y1) return m_act[k].color;
      return m_act_bg;
   endfunction

   function automatic logic [31:0] mk(input int op, input int a);
      return {a[23:0], op[7:0]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_stg[k] = '{0, 0, 0, 0, 0, 1'b0};
      m_act    = m_stg;
      m_stg_bg = 'hf00;
      m_act_bg = 'hf00;
      m_sel    = 0;
      m_pend   = 0;
      m_err    = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: advance the model using the inputs seen at the edge, then compare
   task automatic step();
      int pix, op, a;
      bit cn, cp;
      pix = ref_color(int'(x), int'(y));
      @(posedge clk);
      op = int'(instr[7:0]);
      a  = int'(instr[31:8]);
      if (rst) begin
         model_reset();
         exp_color = 0;
         pipe1     = 0;
      end else begin
         exp_color = pipe1;
         pipe1     = pix;
         cn = rdy && (op == 7);
         cp = fs && (m_pend || cn);
         if (cp) begin
            m_act    = m_stg;
            m_act_bg = m_stg_bg;
         end
         if (cp) m_pend = 0;
         else if (cn) m_pend = 1;
         if (rdy) begin
            case (op)
               1: m_stg_bg = a & 'hfff;
               2: if ((a & 'hff) >= 4) m_err = 1; else m_sel = a & 'hff;
               3: begin m_stg[m_sel].x0 = a & 'h3ff; m_stg[m_sel].x1 = (a >> 12) & 'h3ff; end
               4: begin m_stg[m_sel].y0 = a & 'h3ff; m_stg[m_sel].y1 = (a >> 12) & 'h3ff; end
               5: begin m_stg[m_sel].color = a & 'hfff; m_stg[m_sel].en = a[16]; end
               6: for (int k = 0; k < 4; k++) m_stg[k].en = 0;
               7: ;
               8: m_err = 0;
               default: m_err = 1;
            endcase
         end
      end
      #1;
      check("color", {20'b0, o_color}, exp_color);
      check("pending", {31'b0, o_pend}, {31'b0, m_pend});
      check("error", {31'b0, o_err}, {31'b0, m_err});
   endtask

   task automatic issue(input int op, input int a);
      rdy   = 1'b1;
      instr = mk(op, a);
      step();
      rdy   = 1'b0;
      instr = '0;
   endtask

   task automatic frame();
      fs = 1'b1;
      step();
      fs = 1'b0;
   endtask

   task automatic probe(input int px, input int py, input int exp, input string tag);
      x = px[9:0];
      y = py[9:0];
      step();
      step();
      check(tag, {20'b0, o_color}, exp);
   endtask

   initial begin
      int op, a;
      rst = 1'b1; x = 10'd5; y = 10'd5; fs = 1'b0; instr = '0; rdy = 1'b0;
      pipe1 = 0; exp_color = 0;
      model_reset();
      repeat (3) step();
      check("reset_color", {20'b0, o_color}, 32'h0);
      rst = 1'b0;
      step();
      check("post_reset_1", {20'b0, o_color}, 32'h0);
      step();
      check("post_reset_2", {20'b0, o_color}, 32'hf00);

      // Staging write without commit must not show
      issue(1, 'h0f0);
      frame();
      repeat (3) step();
      check("no_commit_bg", {20'b0, o_color}, 32'hf00);
      issue(7, 0);
      check("pending_set", {31'b0, o_pend}, 32'h1);
      frame();
      step();
      check("copy_old_in_pipe", {20'b0, o_color}, 32'hf00);
      step();
      check("copy_new_bg", {20'b0, o_color}, 32'h0f0);

      // Rect 1 with inclusive bounds
      issue(2, 1);
      issue(3, 10 | (20 << 12));
      issue(4, 10 | (20 << 12));
      issue(5, 'h00f | (1 << 16));
      issue(7, 0);
      frame();
      probe(10, 15, 'h00f, "rect_left_edge");
      probe(20, 15, 'h00f, "rect_right_edge");
      probe(21, 15, 'h0f0, "rect_outside");

      // Priority: rect 0 beats rect 1
      issue(2, 0);
      issue(3, 0 | (50 << 12));
      issue(4, 0 | (50 << 12));
      issue(5, 'hfff | (1 << 16));
      issue(2, 1);
      issue(3, 0 | (50 << 12));
      issue(4, 0 | (50 << 12));
      issue(5, 'h00f | (1 << 16));
      issue(7, 0);
      frame();
      probe(25, 25, 'hfff, "priority_low_index");
      issue(2, 0);
      issue(5, 'hfff);
      issue(7, 0);
      frame();
      probe(25, 25, 'h00f, "rect0_disabled");

      // Error handling; bad SELECT must leave sel at 1
      issue(2, 1);
      issue(2, 9);
      check("select_oob_err", {31'b0, o_err}, 32'h1);
      issue(5, 'h0ff | (1 << 16));
      issue(7, 0);
      frame();
      probe(25, 25, 'h0ff, "sel_unchanged");
      issue('haa, 0);
      check("bad_opcode_err", {31'b0, o_err}, 32'h1);
      issue(8, 0);
      check("clr_err", {31'b0, o_err}, 32'h0);

      // COMMIT coincident with frame start
      issue(1, 'h123);
      fs = 1'b1;
      issue(7, 0);
      fs = 1'b0;
      check("same_cycle_commit", {31'b0, o_pend}, 32'h0);
      probe(200, 200, 'h123, "same_cycle_bg");

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         op = int'($urandom_range(0, 9));
         if (op == 9) op = int'($urandom_range(9, 255));
         case (op)
            2: a = int'($urandom_range(0, 5));
            3, 4: a = int'($urandom_range(0, 127)) | (int'($urandom_range(0, 127)) << 12);
            default: a = int'($urandom_range(0, 32'h00ff_ffff));
         endcase
         rdy   = ($urandom_range(0, 2) != 0);
         instr = mk(op, a);
         fs    = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 299) == 0);
         x     = 10'($urandom_range(0, 127));
         y     = 10'($urandom_range(0, 127));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
